// File: rtl/pico_l15_mem_arbiter_pkg.sv
// Shared definitions for the pico -> L1.5 memory arbiter.
// Holds the FSM state encodings and the pico memory port widths. The AMO
// opcode width comes from the L1.5 headers when they are present. The fallback
// below only applies to standalone builds of this block.
`ifndef L15_AMO_OP_WIDTH
`define L15_AMO_OP_WIDTH 4
`endif

package pico_l15_mem_arbiter_pkg;

    localparam int PICO_MEM_ADDR_W = 32;
    localparam int PICO_MEM_DATA_W = 32;
    localparam int AMO_W           = `L15_AMO_OP_WIDTH;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_BUSY = 2'd1,
        ARB_ST_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pico_l15_mem_arbiter_rr_pick.sv
// pico_rr_pick: combinational round-robin picker.
// Ports:
//   valid      in   NUM_REQ          request vector
//   last_grant in   $clog2(NUM_REQ)  most recently served requester
//   any_valid  out  1                at least one request present
//   pick       out  $clog2(NUM_REQ)  first valid requester after last_grant (cyclic)
module pico_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic                       any_valid,
    output logic [$clog2(NUM_REQ)-1:0] pick
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;
    int   idx;

    // Scan starts one past last_grant so the last winner has lowest priority.
    always_comb begin
        any_valid = |valid;
        pick      = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pico_l15_mem_arbiter.sv
// pico_l15_mem_arbiter: shares one pico-style memory port among NUM_REQ
// requesters in front of the pico->L1.5 transducer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_mem_*                packed per-requester request fields (slot i at [W*i +: W])
//   req_mem_ready/rdata      completion pulse to granted requester, replicated rdata
//   arb_mem_*                registered request to the transducer, plus its ready/rdata
//   grant_id                 current or last granted requester
//   timeout_err              sticky watchdog flag
// Only one transaction is outstanding at a time: IDLE -> BUSY -> DONE -> IDLE.
module pico_l15_mem_arbiter
    import pico_l15_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_mem_valid,
    input  logic [NUM_REQ*PICO_MEM_ADDR_W-1:0]   req_mem_addr,
    input  logic [NUM_REQ*4-1:0]                 req_mem_wstrb,
    input  logic [NUM_REQ*PICO_MEM_DATA_W-1:0]   req_mem_wdata,
    input  logic [NUM_REQ*AMO_W-1:0]             req_mem_amo_op,
    output logic [NUM_REQ-1:0]                   req_mem_ready,
    output logic [NUM_REQ*PICO_MEM_DATA_W-1:0]   req_mem_rdata,
    output logic                                 arb_mem_valid,
    output logic [PICO_MEM_ADDR_W-1:0]           arb_mem_addr,
    output logic [3:0]                           arb_mem_wstrb,
    output logic [PICO_MEM_DATA_W-1:0]           arb_mem_wdata,
    output logic [AMO_W-1:0]                     arb_mem_amo_op,
    input  logic                                 arb_mem_ready,
    input  logic [PICO_MEM_DATA_W-1:0]           arb_mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 timeout_err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // Keep a 1-bit counter when the watchdog is disabled. It never moves.
    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick;
    logic             any_valid;
    logic [WD_W-1:0]  wdog;
    int               sel;

    pico_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid      (req_mem_valid),
        .last_grant (last_grant),
        .any_valid  (any_valid),
        .pick       (pick)
    );

    assign sel = int'(pick);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A hung transducer keeps the FSM in BUSY because the
    // L1.5 request cannot be withdrawn. The watchdog only reports this case.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_ST_IDLE: if (any_valid)     state_nxt = ARB_ST_BUSY;
            ARB_ST_BUSY: if (arb_mem_ready) state_nxt = ARB_ST_DONE;
            ARB_ST_DONE:                    state_nxt = ARB_ST_IDLE;
            default:                        state_nxt = ARB_ST_IDLE;
        endcase
    end

    // Outputs. The ready pulse depends only on the latched grant, so a requester
    // that dropped valid early still gets its completion.
    always_comb begin
        arb_mem_valid = (state == ARB_ST_BUSY);
        req_mem_ready = '0;
        if (state == ARB_ST_BUSY && arb_mem_ready) req_mem_ready[grant_id] = 1'b1;
    end

    assign req_mem_rdata = {NUM_REQ{arb_mem_rdata}};

    // Request field capture, round-robin pointer and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_mem_addr   <= '0;
            arb_mem_wstrb  <= '0;
            arb_mem_wdata  <= '0;
            arb_mem_amo_op <= '0;
            grant_id       <= '0;
            last_grant     <= LAST_RST;
            wdog           <= '0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                ARB_ST_IDLE: begin
                    if (any_valid) begin
                        arb_mem_addr   <= req_mem_addr[sel*PICO_MEM_ADDR_W +: PICO_MEM_ADDR_W];
                        arb_mem_wstrb  <= req_mem_wstrb[sel*4 +: 4];
                        arb_mem_wdata  <= req_mem_wdata[sel*PICO_MEM_DATA_W +: PICO_MEM_DATA_W];
                        arb_mem_amo_op <= req_mem_amo_op[sel*AMO_W +: AMO_W];
                        grant_id       <= pick;
                        wdog           <= '0;
                    end
                end
                ARB_ST_BUSY: begin
                    if (arb_mem_ready) begin
                        last_grant <= grant_id;
                    end else begin
                        if (wdog != WD_MAX) wdog <= wdog + 1'b1;
                        if (TIMEOUT_CYCLES > 0 && wdog == WD_LAST) timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
